// File: rtl/logit_pack_if.sv
// rtl/logit_pack_if.sv - element stream into the logit collector
interface logit_pack_if #(
  parameter int DATA_W = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/logit_pack.sv
// rtl/logit_pack.sv - per-class logit accumulator, saturator and sorter loader
module logit_pack #(
  parameter int N_CLASS = 10,
  parameter int DATA_W  = 16,
  parameter int BEATS   = 4,
  parameter int ACC_W   = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  logit_pack_if.slave               s,
  input  logic [N_CLASS*DATA_W-1:0] bias,
  input  logic                      sort_done,
  output logic                      load,
  output logic [N_CLASS*DATA_W-1:0] data,
  output logic                      frame_err,
  output logic                      busy
);
  localparam int CW = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] CLS_LAST  = CW'(N_CLASS - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {ACC, SAT, LD1, LD2, WAIT} state_t;

  state_t                    state;
  logic [CW-1:0]             cls_cnt;
  logic [BW-1:0]             beat_cnt;
  logic signed [ACC_W-1:0]   acc [N_CLASS];
  logic [N_CLASS*DATA_W-1:0] bias_q;
  logic signed [ACC_W:0]     tot [N_CLASS];
  logic [N_CLASS*DATA_W-1:0] sat_bus;

  logic             accept;
  logic             first_elem;
  logic             final_elem;
  logic [ACC_W-1:0] s_ext;

  assign accept     = s.s_valid && s.s_ready;
  assign first_elem = (cls_cnt == '0) && (beat_cnt == '0);
  assign final_elem = (cls_cnt == CLS_LAST) && (beat_cnt == BEAT_LAST);
  assign s_ext      = {{(ACC_W-DATA_W){s.s_data[DATA_W-1]}}, s.s_data};

  // Totals are formed one bit wider than the accumulator so acc+bias never wraps before clamping.
  always_comb begin
    sat_bus = '0;
    for (int c = 0; c < N_CLASS; c++) begin
      tot[c] = {acc[c][ACC_W-1], acc[c]}
             + {{(ACC_W+1-DATA_W){bias_q[(N_CLASS-1-c)*DATA_W + DATA_W-1]}},
                bias_q[(N_CLASS-1-c)*DATA_W +: DATA_W]};
      if (tot[c] > SAT_MAX)
        sat_bus[(N_CLASS-1-c)*DATA_W +: DATA_W] = {1'b0, {(DATA_W-1){1'b1}}};
      else if (tot[c] < SAT_MIN)
        sat_bus[(N_CLASS-1-c)*DATA_W +: DATA_W] = {1'b1, {(DATA_W-1){1'b0}}};
      else
        sat_bus[(N_CLASS-1-c)*DATA_W +: DATA_W] = tot[c][DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      cls_cnt   <= '0;
      beat_cnt  <= '0;
      bias_q    <= '0;
      s.s_ready <= 1'b1;
      load      <= 1'b0;
      data      <= '0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      for (int c = 0; c < N_CLASS; c++) acc[c] <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ACC: begin
          if (accept) begin
            if (first_elem) bias_q <= bias;
            if (final_elem) begin
              for (int c = 0; c < N_CLASS; c++)
                if (cls_cnt == CW'(c)) acc[c] <= acc[c] + s_ext;
              frame_err <= !s.s_last;
              s.s_ready <= 1'b0;
              busy      <= 1'b1;
              state     <= SAT;
            end else if (s.s_last) begin
              // Premature end of frame: drop everything gathered so far.
              for (int c = 0; c < N_CLASS; c++) acc[c] <= '0;
              cls_cnt   <= '0;
              beat_cnt  <= '0;
              frame_err <= 1'b1;
              busy      <= 1'b0;
            end else begin
              for (int c = 0; c < N_CLASS; c++)
                if (cls_cnt == CW'(c)) acc[c] <= acc[c] + s_ext;
              if (cls_cnt == CLS_LAST) begin
                cls_cnt  <= '0;
                beat_cnt <= beat_cnt + 1'b1;
              end else begin
                cls_cnt <= cls_cnt + 1'b1;
              end
              busy <= 1'b1;
            end
          end
        end
        SAT: begin
          data     <= sat_bus;
          for (int c = 0; c < N_CLASS; c++) acc[c] <= '0;
          cls_cnt  <= '0;
          beat_cnt <= '0;
          load     <= 1'b1;
          state    <= LD1;
        end
        LD1: state <= LD2;
        LD2: begin
          load  <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          if (sort_done) begin
            s.s_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ACC;
          end
        end
        default: begin
          s.s_ready <= 1'b1;
          load      <= 1'b0;
          busy      <= 1'b0;
          state     <= ACC;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_logit_pack.sv
// tb/tb_logit_pack.sv - directed bench with a frame-level score model for logit_pack
module tb_logit_pack;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logit_pack_if #(.DATA_W(16)) s_if ();
  logic [159:0] bias;
  logic         sort_done;
  logic         load;
  logic [159:0] data;
  logic         frame_err;
  logic         busy;

  logit_pack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (s_if),
    .bias      (bias),
    .sort_done (sort_done),
    .load      (load),
    .data      (data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int checks = 0;
  int failures = 0;
  int elem [40];
  logic [159:0] exp_q [$];
  int n_load = 0;
  int n_ferr = 0;

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Scores straight from the rules: sum the elements of each class, add bias, clamp.
  function automatic logic [159:0] model_frame(input logic [159:0] b);
    logic [159:0] r = '0;
    for (int c = 0; c < 10; c++) begin
      int sum = int'($signed(b[(9-c)*16 +: 16]));
      for (int k = 0; k < 40; k++)
        if (k % 10 == c) sum += elem[k];
      if (sum > 32767) sum = 32767;
      if (sum < -32768) sum = -32768;
      r[(9-c)*16 +: 16] = 16'(sum);
    end
    return r;
  endfunction

  initial begin
    int run = 0;
    logic [159:0] cur = '0;
    logic load_d = 1'b0;
    logic ferr_d = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0; load_d = 1'b0; ferr_d = 1'b0;
      end else begin
        if (load && !load_d) begin
          n_load++;
          chk("load_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) cur = exp_q.pop_front();
        end
        if (load) begin
          run++;
          chk("load_data", data, cur);
          chk("ready_during_load", s_if.s_ready, 0);
          chk("busy_during_load", busy, 1);
        end else if (run != 0) begin
          chk("load_width", run, 2);
          run = 0;
        end
        if (frame_err) n_ferr++;
        chk("ferr_width", frame_err && ferr_d, 0);
        load_d = load;
        ferr_d = frame_err;
      end
    end
  end

  task automatic drive_elems(input int n, input int last_at, input logic [159:0] b, input bit push);
    bias = b;
    for (int k = 0; k < n; k++) begin
      int t = 0;
      s_if.s_valid = 1'b1;
      s_if.s_data  = 16'(elem[k]);
      s_if.s_last  = (k == last_at);
      while (!s_if.s_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("ready_wait", s_if.s_ready, 1);
      if (t >= 200) break;
      @(posedge clk);
      @(negedge clk);
    end
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    if (push) exp_q.push_back(model_frame(b));
  endtask

  task automatic wait_load_end();
    int t = 0;
    while (!load && t < 50) begin @(negedge clk); t++; end
    while (load && t < 50) begin @(negedge clk); t++; end
    chk("load_window", t < 50, 1);
    chk("wait_ready", s_if.s_ready, 0);
    chk("wait_busy", busy, 1);
  endtask

  task automatic pulse_done();
    sort_done = 1'b1;
    @(negedge clk);
    sort_done = 1'b0;
    chk("ready_after_done", s_if.s_ready, 1);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [159:0] b;
    logic [159:0] m;
    logic [159:0] e;
    int ld0;
    int fe0;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    s_if.s_last  = 1'b0;
    bias = '0;
    sort_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", s_if.s_ready, 1);
    chk("rst_load", load, 0);
    chk("rst_data", data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean frame of ones
    for (int k = 0; k < 40; k++) elem[k] = 1;
    chk("t1_model", model_frame('0), {10{16'h0004}});
    ld0 = n_load; fe0 = n_ferr;
    drive_elems(40, 39, '0, 1);
    wait_load_end();
    pulse_done();
    chk("t1_loads", n_load - ld0, 1);
    chk("t1_ferr", n_ferr - fe0, 0);
    chk("t1_data", data, {10{16'h0004}});

    // Saturation at both rails
    for (int k = 0; k < 40; k++) elem[k] = (k % 10 == 0) ? 30000 : (k % 10 == 1) ? -30000 : k;
    b = {16'd10000, 144'h0};
    m = model_frame(b);
    chk("t2_model_l0", m[159:144], 16'h7fff);
    chk("t2_model_l1", m[143:128], 16'h8000);
    drive_elems(40, 39, b, 1);
    wait_load_end();
    pulse_done();
    chk("t2_lane0", data[159:144], 16'h7fff);
    chk("t2_lane1", data[143:128], 16'h8000);

    // Early s_last on element 17, then a clean frame with per-class bias
    for (int k = 0; k < 40; k++) elem[k] = k;
    ld0 = n_load; fe0 = n_ferr;
    drive_elems(18, 17, '0, 0);
    repeat (4) @(negedge clk);
    chk("t3_ferr", n_ferr - fe0, 1);
    chk("t3_noload", n_load - ld0, 0);
    chk("t3_ready", s_if.s_ready, 1);
    chk("t3_busy", busy, 0);
    b = '0;
    e = '0;
    for (int c = 0; c < 10; c++) begin
      b[(9-c)*16 +: 16] = 16'(7*c - 20);
      e[(9-c)*16 +: 16] = 16'(11*c + 40);
    end
    m = model_frame(b);
    chk("t3_model_l9", m[15:0], 16'd139);
    drive_elems(40, 39, b, 1);
    wait_load_end();
    pulse_done();
    chk("t3_data", data, e);

    // Missing s_last on element 39
    for (int k = 0; k < 40; k++) elem[k] = (k % 2 == 1) ? -3 : 5;
    ld0 = n_load; fe0 = n_ferr;
    drive_elems(40, -1, '0, 1);
    wait_load_end();
    pulse_done();
    chk("t4_ferr", n_ferr - fe0, 1);
    chk("t4_loads", n_load - ld0, 1);
    chk("t4_lane0", data[159:144], 16'd20);
    chk("t4_lane1", data[143:128], 16'hfff4);

    // Backpressure: next frame offered while the sorter is still working
    for (int k = 0; k < 40; k++) elem[k] = 2;
    drive_elems(40, 39, '0, 1);
    wait_load_end();
    for (int k = 0; k < 40; k++) elem[k] = (k % 10) * 100 + k / 10;
    s_if.s_valid = 1'b1;
    s_if.s_data  = 16'(elem[0]);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_held", s_if.s_ready, 0);
    end
    pulse_done();
    drive_elems(40, 39, '0, 1);
    wait_load_end();
    pulse_done();
    chk("t5_lane0", data[159:144], 16'd6);
    chk("t5_lane9", data[15:0], 16'd3606);

    // Asynchronous reset part-way through a frame
    for (int k = 0; k < 40; k++) elem[k] = 50;
    ld0 = n_load;
    drive_elems(21, -1, '0, 0);
    chk("t6_busy_mid", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_ready", s_if.s_ready, 1);
    chk("t6_load", load, 0);
    chk("t6_data", data, 0);
    chk("t6_ferr", frame_err, 0);
    chk("t6_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_noload", n_load - ld0, 0);
    for (int k = 0; k < 40; k++) elem[k] = (k % 10) - 4;
    drive_elems(40, 39, '0, 1);
    wait_load_end();
    pulse_done();
    chk("t6_lane0", data[159:144], 16'hfff0);
    chk("t6_lane9", data[15:0], 16'd20);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
